// File: rtl/fft_pkg.sv
// fft_pkg -- shared constants and address map for the radix-2 FFT datapath.
// Used by fft_addr_gen and by the compute driver so both agree on the
// operand/twiddle addressing of every butterfly.
package fft_pkg;

   // Result of the address map, wide enough for any supported FFT length.
   // Callers slice the fields down to their own widths.
   typedef struct packed {
      logic [31:0] addr_a;
      logic [31:0] addr_b;
      logic [31:0] tw;
   } fft_map_t;

   // Operand address width: L = log2(N).
   function automatic int unsigned fft_addr_w(input int unsigned n);
      return $clog2(n);
   endfunction

   // Twiddle ROM index width: L-1 (ROM holds N/2 entries).
   function automatic int unsigned fft_tw_w(input int unsigned n);
      return $clog2(n) - 1;
   endfunction

   // Stage index width: enough to count 0..L-1.
   function automatic int unsigned fft_stage_w(input int unsigned n);
      return $clog2($clog2(n));
   endfunction

   // Butterfly address map for stage s, pair p of an FFT with L address bits.
   //   h      = 2^s
   //   addr_a = ((p >> s) << (s+1)) | (p & (h-1))
   //   addr_b = addr_a + h            (kept to L bits)
   //   tw     = (p & (h-1)) << (L-1-s) (kept to L-1 bits)
   // An out-of-range stage maps to all zeros; the caller rejects it anyway.
   function automatic fft_map_t fft_addr_map(input int unsigned l,
                                             input int unsigned s,
                                             input int unsigned p);
      fft_map_t    m;
      logic [31:0] h;
      logic [31:0] lo;
      logic [31:0] a_mask;
      logic [31:0] tw_mask;
      m = '0;
      if (s < l) begin
         h        = 32'd1 << s;
         lo       = p & (h - 32'd1);
         a_mask   = (32'd1 << l) - 32'd1;
         tw_mask  = (32'd1 << (l - 1)) - 32'd1;
         m.addr_a = (((p >> s) << (s + 1)) | lo) & a_mask;
         m.addr_b = (m.addr_a + h) & a_mask;
         m.tw     = (lo << (l - 1 - s)) & tw_mask;
      end
      return m;
   endfunction

endpackage

// File: rtl/fft_delay_line.sv
// fft_delay_line -- fixed-depth valid/data shift pipeline with synchronous
// clear. Data moves only together with its valid bit, so the output data
// holds the last delivered entry during bubbles.
module fft_delay_line #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 3
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   logic [DEPTH-1:0] vld;
   logic [WIDTH-1:0] dat [DEPTH];

   // Shift valid every cycle; advance data only where a valid entry moves.
   always_ff @(posedge clk) begin
      if (clear) begin
         vld <= '0;
         // NOTE: the data stages are cleared too (not just the valid bits)
         // because the tail stage drives the write-address outputs, which
         // must read zero after reset.
         for (int i = 0; i < DEPTH; i++) begin
            dat[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments let every stage read its
         // neighbour's pre-edge value, so the chain shifts by exactly one.
         vld[0] <= in_valid;
         if (in_valid) begin
            dat[0] <= in_data;
         end
         for (int i = 1; i < DEPTH; i++) begin
            vld[i] <= vld[i-1];
            if (vld[i-1]) begin
               dat[i] <= dat[i-1];
            end
         end
      end
   end

   assign out_valid = vld[DEPTH-1];
   assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/fft_addr_gen.sv
// fft_addr_gen -- butterfly read/write address generator for an in-place,
// ping-pong radix-2 FFT. Maps (stage, pair_id) to operand and twiddle
// addresses, then replays the operand addresses as write addresses once the
// butterfly result emerges BFLY_LATENCY cycles later.
// Optional build macro FFT_BITREV_EN: bit-reverse the stage-0 read addresses
// so natural-order input is consumed (write addresses stay natural).
module fft_addr_gen
   import fft_pkg::*;
#(
   parameter int N            = 32,
   parameter int BFLY_LATENCY = 3
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [fft_stage_w(N)-1:0]   stage,
   input  logic [$clog2(N/2)-1:0]      pair_id,
   input  logic                        valid,
   input  logic                        bank_select,
   output logic [fft_addr_w(N)-1:0]    rd_addr_a,
   output logic [fft_addr_w(N)-1:0]    rd_addr_b,
   output logic [fft_tw_w(N)-1:0]      tw_addr,
   output logic                        rd_valid,
   output logic                        rd_bank,
   output logic [fft_addr_w(N)-1:0]    wr_addr_a,
   output logic [fft_addr_w(N)-1:0]    wr_addr_b,
   output logic                        wr_en,
   output logic                        wr_bank,
   output logic                        pipeline_clear,
   output logic                        addr_err
);

   localparam int unsigned L     = fft_addr_w(N);
   localparam int          AW    = fft_addr_w(N);
   localparam int          TW    = fft_tw_w(N);
   localparam int          SW    = fft_stage_w(N);
   localparam int          PW    = $clog2(N/2);
   localparam int          DW    = 2 * AW + 1;
   localparam int          CNT_W = $clog2(BFLY_LATENCY + 2);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BFLY_LATENCY + 1);

   typedef struct packed {
      logic [AW-1:0] a;
      logic [AW-1:0] b;
      logic [TW-1:0] tw;
   } req_map_t;

   // Narrow the shared address map to this instance's widths.
   function automatic req_map_t map_req(input logic [SW-1:0] s,
                                        input logic [PW-1:0] p);
      fft_map_t m;
      m = fft_addr_map(L, 32'(s), 32'(p));
      map_req.a  = m.addr_a[AW-1:0];
      map_req.b  = m.addr_b[AW-1:0];
      map_req.tw = m.tw[TW-1:0];
   endfunction

`ifdef FFT_BITREV_EN
   function automatic logic [AW-1:0] bit_rev(input logic [AW-1:0] x);
      for (int i = 0; i < AW; i++) begin
         bit_rev[i] = x[AW-1-i];
      end
   endfunction
`endif

   req_map_t         req;
   logic             stage_ok;
   logic             accept;
   logic [AW-1:0]    rd_a_next;
   logic [AW-1:0]    rd_b_next;
   logic [AW-1:0]    wr_src_a;
   logic [AW-1:0]    wr_src_b;
   logic [DW-1:0]    dl_in;
   logic [DW-1:0]    dl_out;
   logic [CNT_W-1:0] inflight;

   assign req      = map_req(stage, pair_id);
   assign stage_ok = (32'(stage) < L);
   assign accept   = valid && stage_ok;

   // Select the read addresses actually presented to the memory.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no
      // latch is inferred when the optional branch below is skipped.
      rd_a_next = req.a;
      rd_b_next = req.b;
`ifdef FFT_BITREV_EN
      if (stage == '0) begin
         rd_a_next = bit_rev(req.a);
         rd_b_next = bit_rev(req.b);
      end
`endif
   end

   // Read-side registers: strobe every cycle, addresses only on acceptance.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid  <= 1'b0;
         rd_addr_a <= '0;
         rd_addr_b <= '0;
         tw_addr   <= '0;
         rd_bank   <= 1'b0;
      end else begin
         rd_valid <= accept;
         if (accept) begin
            rd_addr_a <= rd_a_next;
            rd_addr_b <= rd_b_next;
            tw_addr   <= req.tw;
            rd_bank   <= bank_select;
         end
      end
   end

`ifdef FFT_BITREV_EN
   logic [AW-1:0] nat_addr_a;
   logic [AW-1:0] nat_addr_b;

   // Keep the natural-order addresses alongside the (possibly reversed)
   // read addresses; results are always written back in natural order.
   always_ff @(posedge clk) begin
      if (reset) begin
         nat_addr_a <= '0;
         nat_addr_b <= '0;
      end else if (accept) begin
         nat_addr_a <= req.a;
         nat_addr_b <= req.b;
      end
   end

   assign wr_src_a = nat_addr_a;
   assign wr_src_b = nat_addr_b;
`else
   assign wr_src_a = rd_addr_a;
   assign wr_src_b = rd_addr_b;
`endif

   assign dl_in = {wr_src_a, wr_src_b, ~rd_bank};

   fft_delay_line #(
      .WIDTH (DW),
      .DEPTH (BFLY_LATENCY)
   ) u_delay (
      .clk       (clk),
      .clear     (reset),
      .in_valid  (rd_valid),
      .in_data   (dl_in),
      .out_valid (wr_en),
      .out_data  (dl_out)
   );

   assign wr_addr_a = dl_out[DW-1 -: AW];
   assign wr_addr_b = dl_out[AW:1];
   assign wr_bank   = dl_out[0];

   // In-flight count: +1 on acceptance, -1 on write; both cancel out.
   always_ff @(posedge clk) begin
      if (reset) begin
         inflight <= '0;
      end else begin
         case ({accept, wr_en})
            2'b10: if (inflight != CNT_MAX) inflight <= inflight + CNT_W'(1);
            2'b01: if (inflight != '0)      inflight <= inflight - CNT_W'(1);
            default: ;
         endcase
      end
   end

   // Sticky error on a request for a stage beyond the last one.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_err <= 1'b0;
      end else if (valid && !stage_ok) begin
         addr_err <= 1'b1;
      end
   end

   assign pipeline_clear = !valid && (inflight == '0);

endmodule

// File: tb/tb_fft_addr_gen.sv
// tb_fft_addr_gen -- directed self-checking bench for fft_addr_gen with
// N=32, BFLY_LATENCY=3. Expected values are hand-computed from the address
// map. Inputs change 1ns after the rising edge; outputs are sampled there.
module tb_fft_addr_gen;

   localparam int N   = 32;
   localparam int LAT = 3;
   localparam int AW  = 5;
   localparam int TW  = 4;
   localparam int SW  = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic [SW-1:0] stage;
   logic [TW-1:0] pair_id;
   logic          valid;
   logic          bank_select;
   logic [AW-1:0] rd_addr_a;
   logic [AW-1:0] rd_addr_b;
   logic [TW-1:0] tw_addr;
   logic          rd_valid;
   logic          rd_bank;
   logic [AW-1:0] wr_addr_a;
   logic [AW-1:0] wr_addr_b;
   logic          wr_en;
   logic          wr_bank;
   logic          pipeline_clear;
   logic          addr_err;

   int checks   = 0;
   int failures = 0;

   // Stage-1 operand A addresses for pairs 0..15 (operand B is A+2).
   int burst_a [16] = '{0, 1, 4, 5, 8, 9, 12, 13, 16, 17, 20, 21, 24, 25, 28, 29};

   always #5 clk = ~clk;

   fft_addr_gen #(
      .N            (N),
      .BFLY_LATENCY (LAT)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .stage          (stage),
      .pair_id        (pair_id),
      .valid          (valid),
      .bank_select    (bank_select),
      .rd_addr_a      (rd_addr_a),
      .rd_addr_b      (rd_addr_b),
      .tw_addr        (tw_addr),
      .rd_valid       (rd_valid),
      .rd_bank        (rd_bank),
      .wr_addr_a      (wr_addr_a),
      .wr_addr_b      (wr_addr_b),
      .wr_en          (wr_en),
      .wr_bank        (wr_bank),
      .pipeline_clear (pipeline_clear),
      .addr_err       (addr_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One isolated butterfly: read phase, idle gap, write phase, drain.
   task automatic single_op(input logic [SW-1:0] stg, input logic [TW-1:0] pr,
                            input logic bnk, input int exp_rd_a, input int exp_rd_b,
                            input int exp_tw, input int exp_wr_a, input int exp_wr_b);
      stage       = stg;
      pair_id     = pr;
      bank_select = bnk;
      valid       = 1'b1;
      #1;
      check("clear_low_while_req", pipeline_clear, 0);
      step();
      valid = 1'b0;
      check("op_rd_valid", rd_valid, 1);
      check("op_rd_a", rd_addr_a, exp_rd_a);
      check("op_rd_b", rd_addr_b, exp_rd_b);
      check("op_tw", tw_addr, exp_tw);
      check("op_rd_bank", rd_bank, bnk);
      check("op_wr_early", wr_en, 0);
      for (int i = 1; i < LAT; i++) begin
         step();
         check("op_rd_idle", rd_valid, 0);
         check("op_wr_idle", wr_en, 0);
      end
      step();
      check("op_wr_en", wr_en, 1);
      check("op_wr_a", wr_addr_a, exp_wr_a);
      check("op_wr_b", wr_addr_b, exp_wr_b);
      check("op_wr_bank", wr_bank, !bnk);
      check("op_rd_a_held", rd_addr_a, exp_rd_a);
      check("op_clear_busy", pipeline_clear, 0);
      step();
      check("op_wr_done", wr_en, 0);
      check("op_clear_idle", pipeline_clear, 1);
   endtask

   initial begin
      // Reset, with a request presented that must be ignored.
      reset       = 1'b1;
      valid       = 1'b1;
      stage       = '0;
      pair_id     = 4'd5;
      bank_select = 1'b1;
      step();
      check("rst_rd_valid", rd_valid, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_addr_err", addr_err, 0);
      check("rst_rd_a", rd_addr_a, 0);
      check("rst_rd_b", rd_addr_b, 0);
      check("rst_tw", tw_addr, 0);
      check("rst_wr_a", wr_addr_a, 0);
      check("rst_wr_b", wr_addr_b, 0);
      check("rst_rd_bank", rd_bank, 0);
      check("rst_wr_bank", wr_bank, 0);
      check("rst_clear_valid_hi", pipeline_clear, 0);
      valid = 1'b0;
      #1;
      check("rst_clear_valid_lo", pipeline_clear, 1);
      step();
      reset = 1'b0;
      step();

      // Directed single butterflies.
`ifdef FFT_BITREV_EN
      single_op(3'd0, 4'd5, 1'b0, 10, 26, 0, 10, 11);
`else
      single_op(3'd0, 4'd5, 1'b0, 10, 11, 0, 10, 11);
`endif
      single_op(3'd2, 4'd5,  1'b1, 9,  13, 4,  9,  13);
      single_op(3'd4, 4'd15, 1'b0, 15, 31, 15, 15, 31);
      single_op(3'd3, 4'd13, 1'b1, 21, 29, 10, 21, 29);
      single_op(3'd1, 4'd7,  1'b0, 13, 15, 8,  13, 15);

      // 16 back-to-back stage-1 pairs.
      for (int k = 0; k < 22; k++) begin
         valid       = (k < 16);
         stage       = 3'd1;
         pair_id     = 4'(k);
         bank_select = 1'b0;
         step();
         check("burst_rd_valid", rd_valid, (k < 16));
         if (k < 16) begin
            check("burst_rd_a", rd_addr_a, burst_a[k]);
            check("burst_rd_b", rd_addr_b, burst_a[k] + 2);
         end
         check("burst_wr_en", wr_en, (k >= LAT && k < 16 + LAT));
         if (k >= LAT && k < 16 + LAT) begin
            check("burst_wr_a", wr_addr_a, burst_a[k-LAT]);
            check("burst_wr_b", wr_addr_b, burst_a[k-LAT] + 2);
         end
         check("burst_clear", pipeline_clear, (k >= 16 + LAT));
      end
      valid = 1'b0;

      // Reset with three operations in flight: none may be written.
      stage       = 3'd0;
      bank_select = 1'b0;
      valid       = 1'b1;
      for (int k = 0; k < 3; k++) begin
         pair_id = 4'(k);
         step();
      end
      valid = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("flush_rd_valid", rd_valid, 0);
      check("flush_rd_a", rd_addr_a, 0);
      check("flush_wr_a", wr_addr_a, 0);
      check("flush_clear", pipeline_clear, 1);
      for (int k = 0; k < 6; k++) begin
         step();
         check("flush_no_wr", wr_en, 0);
         check("flush_clear_hold", pipeline_clear, 1);
      end

      // Out-of-range stage: ignored, sticky error until reset.
      stage   = 3'd5;
      pair_id = 4'd3;
      valid   = 1'b1;
      step();
      valid = 1'b0;
      check("bad_rd_valid", rd_valid, 0);
      check("bad_addr_err", addr_err, 1);
      check("bad_rd_a_held", rd_addr_a, 0);
      for (int k = 0; k < 5; k++) begin
         step();
         check("bad_no_wr", wr_en, 0);
         check("bad_err_sticky", addr_err, 1);
         check("bad_clear", pipeline_clear, 1);
      end
      stage   = 3'd2;
      pair_id = 4'd5;
      valid   = 1'b1;
      step();
      valid = 1'b0;
      check("err_good_rd_valid", rd_valid, 1);
      check("err_good_rd_a", rd_addr_a, 9);
      check("err_still_set", addr_err, 1);
      for (int k = 0; k < 4; k++) begin
         step();
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("err_cleared", addr_err, 0);
      step();
      check("err_stays_clear", addr_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
